// File: rtl/noc_pkg.sv
// Shared NoC types, flit field offsets, port constants and the XY route helper.
// FLIT_DATA_WIDTH falls back to 32 when the build does not set it.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

package noc_pkg;

   typedef enum logic [1:0] {
      BODY     = 2'b00,
      TAIL     = 2'b01,
      HEAD     = 2'b10,
      HEADTAIL = 2'b11
   } flit_type_e;

   typedef enum logic [1:0] {
      IDLE,
      ROUTING,
      VA_WAIT,
      ACTIVE
   } vc_state_e;

   // Field positions counted down from the flit MSB: bit W-HEAD_OFS marks a
   // head, bit W-TAIL_OFS marks a tail, dest starts at bit W-DEST_OFS.
   localparam int HEAD_OFS = 1;
   localparam int TAIL_OFS = 2;
   localparam int DEST_OFS = 3;

   localparam int PORT_LOCAL = 0;
   localparam int PORT_N     = 1;
   localparam int PORT_S     = 2;
   localparam int PORT_E     = 3;
   localparam int PORT_W     = 4;

   // Dimension-ordered routing: X first, then Y. Row index grows southward.
   function automatic int route_compute(int cur_id, int dst_id, int per_row);
      int cx, cy, dx, dy;
      cx = cur_id % per_row;
      cy = cur_id / per_row;
      dx = dst_id % per_row;
      dy = dst_id / per_row;
      if (dx > cx) return PORT_E;
      if (dx < cx) return PORT_W;
      if (dy > cy) return PORT_S;
      if (dy < cy) return PORT_N;
      return PORT_LOCAL;
   endfunction

endpackage

// File: rtl/vc_buffer.sv
// Per-VC circular flit FIFO. Head is combinational off the read pointer;
// a push into a full buffer is accepted only if a pop frees a slot that cycle.
module vc_buffer #(
   parameter  int DEPTH    = 8,
   parameter  int WIDTH    = 32,
   localparam int PTR_BITS = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [WIDTH-1:0]  din,
   output logic [WIDTH-1:0]  dout,
   output logic [PTR_BITS:0] count
);

   logic [WIDTH-1:0]    mem [DEPTH];
   logic [PTR_BITS-1:0] rd_ptr, wr_ptr;
   logic                full, empty, wr_en, rd_en;

   assign full  = (count == (PTR_BITS+1)'(DEPTH));
   assign empty = (count == '0);
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_BITS'(1);
         if (rd_en) rd_ptr <= rd_ptr + PTR_BITS'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + (PTR_BITS+1)'(1);
            2'b01:   count <= count - (PTR_BITS+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; clearing the pointers discards its contents.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/vc_input_unit.sv
// Wormhole VC router input port: per-VC buffers, route/VA/SA state machines, credits.
// Define VC_INPUT_UNIT_OCCUPANCY_EN to expose per-VC occupancy and hol_stall.
module vc_input_unit
   import noc_pkg::*;
#(
   parameter  int NUM_PORTS      = 5,
   parameter  int NUM_VC         = 4,
   parameter  int BUFFER_DEPTH   = 8,
   parameter  int FLIT_WIDTH     = `FLIT_DATA_WIDTH,
   parameter  int NUM_ROUTERS    = 16,
   parameter  int ROUTER_PER_ROW = 4,
   parameter  int ROUTER_ID      = 0,
   localparam int VC_BITS        = $clog2(NUM_VC),
   localparam int PTR_BITS       = $clog2(BUFFER_DEPTH),
   localparam int ROUTER_ID_BITS = $clog2(NUM_ROUTERS)
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  in_valid,
   input  logic [VC_BITS-1:0]                    in_vc,
   input  logic [FLIT_WIDTH-1:0]                 in_flit,
   output logic                                  upstr_credit,
   output logic [VC_BITS-1:0]                    upstr_credit_vc,
   output logic [NUM_VC-1:0]                     va_req,
   output logic [NUM_VC-1:0][NUM_PORTS-1:0]      va_dst_port,
   input  logic [NUM_VC-1:0]                     va_grant,
   input  logic [NUM_VC-1:0][VC_BITS-1:0]        va_grant_vc,
   output logic [NUM_VC-1:0]                     sa_req,
   input  logic [NUM_VC-1:0]                     sa_grant,
   output logic                                  out_valid,
   output logic [FLIT_WIDTH-1:0]                 out_flit,
   output logic [NUM_PORTS-1:0]                  out_port,
   output logic [VC_BITS-1:0]                    out_vc,
`ifdef VC_INPUT_UNIT_OCCUPANCY_EN
   output logic [NUM_VC-1:0][PTR_BITS:0]         occupancy,
   output logic [NUM_VC-1:0]                     hol_stall,
`endif
   output logic [1:0]                            err_flags
);

   function automatic logic [NUM_PORTS-1:0] index_2_one_hot(int idx);
      logic [NUM_PORTS-1:0] oh;
      for (int p = 0; p < NUM_PORTS; p++) oh[p] = (p == idx);
      return oh;
   endfunction

   logic [NUM_VC-1:0][FLIT_WIDTH-1:0] head_flit;
   logic [NUM_VC-1:0][PTR_BITS:0]     count;
   logic [NUM_VC-1:0][NUM_PORTS-1:0]  route_v;
   logic [NUM_VC-1:0][VC_BITS-1:0]    ovc_v;
   logic [NUM_VC-1:0] empty, full, push, pop, sa_pop, discard, discard_req, is_vawait;
   logic              sa_onehot, sa_ok, err_full, err_ill;
   logic [FLIT_WIDTH-1:0] sel_flit;
   logic [NUM_PORTS-1:0]  sel_port;
   logic [VC_BITS-1:0]    sel_ovc, pop_vc;

   // A grant only pops when it is one-hot and lands on a requesting VC.
   assign sa_onehot = (sa_grant != '0) && ((sa_grant & (sa_grant - NUM_VC'(1))) == '0);
   assign sa_ok     = sa_onehot && ((sa_grant & ~sa_req) == '0);
   assign sa_pop    = sa_ok ? sa_grant : '0;

   // Stray BODY/TAIL heads are flushed one VC per cycle, only when SA leaves the credit slot free.
   assign discard = (sa_pop == '0) ? (discard_req & (~discard_req + NUM_VC'(1))) : '0;
   assign pop     = sa_pop | discard;

   assign err_full = in_valid && full[in_vc] && !pop[in_vc];
   assign err_ill  = ((sa_grant != '0) && !sa_ok) || ((va_grant & ~is_vawait) != '0)
                   || (discard != '0);

   for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
      vc_state_e            state_q, state_d;
      logic [NUM_PORTS-1:0] route_q;
      logic [VC_BITS-1:0]   ovc_q;
      logic                 head_is_head, head_is_tail;

      assign push[g] = in_valid && (in_vc == VC_BITS'(g));

      vc_buffer #(.DEPTH(BUFFER_DEPTH), .WIDTH(FLIT_WIDTH)) u_buf (
         .clk   (clk),
         .reset (reset),
         .push  (push[g]),
         .pop   (pop[g]),
         .din   (in_flit),
         .dout  (head_flit[g]),
         .count (count[g])
      );

      assign empty[g]     = (count[g] == '0);
      assign full[g]      = (count[g] == (PTR_BITS+1)'(BUFFER_DEPTH));
      assign head_is_head = head_flit[g][FLIT_WIDTH-HEAD_OFS];
      assign head_is_tail = head_flit[g][FLIT_WIDTH-TAIL_OFS];

      assign discard_req[g] = (state_q == IDLE) && !empty[g] && !head_is_head;
      assign is_vawait[g]   = (state_q == VA_WAIT);
      assign va_req[g]      = (state_q == VA_WAIT);
      assign va_dst_port[g] = (state_q == VA_WAIT) ? route_q : '0;
      assign sa_req[g]      = (state_q == ACTIVE) && !empty[g];
      assign route_v[g]     = route_q;
      assign ovc_v[g]       = ovc_q;

      always_comb begin
         state_d = state_q;
         case (state_q)
            IDLE:    if (!empty[g] && head_is_head) state_d = ROUTING;
            ROUTING: state_d = VA_WAIT;
            VA_WAIT: if (va_grant[g]) state_d = ACTIVE;
            ACTIVE:  if (sa_pop[g] && head_is_tail) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            state_q <= IDLE;
            route_q <= '0;
            ovc_q   <= '0;
         end else begin
            state_q <= state_d;
            if (state_q == ROUTING)
               route_q <= index_2_one_hot(route_compute(ROUTER_ID,
                  int'(head_flit[g][FLIT_WIDTH-DEST_OFS -: ROUTER_ID_BITS]), ROUTER_PER_ROW));
            if ((state_q == VA_WAIT) && va_grant[g]) ovc_q <= va_grant_vc[g];
         end
      end
   end

   // pop is at most one-hot, so a priority scan is a plain mux.
   always_comb begin
      sel_flit = '0;
      sel_port = '0;
      sel_ovc  = '0;
      pop_vc   = '0;
      for (int i = 0; i < NUM_VC; i++) begin
         if (pop[i]) begin
            sel_flit = head_flit[i];
            sel_port = route_v[i];
            sel_ovc  = ovc_v[i];
            pop_vc   = VC_BITS'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid       <= 1'b0;
         out_flit        <= '0;
         out_port        <= '0;
         out_vc          <= '0;
         upstr_credit    <= 1'b0;
         upstr_credit_vc <= '0;
         err_flags       <= '0;
      end else begin
         out_valid       <= (sa_pop != '0);
         out_flit        <= (sa_pop != '0) ? sel_flit : '0;
         out_port        <= (sa_pop != '0) ? sel_port : '0;
         out_vc          <= (sa_pop != '0) ? sel_ovc  : '0;
         upstr_credit    <= (pop != '0);
         upstr_credit_vc <= pop_vc;
         err_flags       <= err_flags | {err_ill, err_full};
      end
   end

`ifdef VC_INPUT_UNIT_OCCUPANCY_EN
   assign occupancy = count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) hol_stall <= '0;
      else        hol_stall <= sa_req & ~sa_pop;
   end
`endif

endmodule

// File: tb/tb_vc_input_unit.sv
// Directed bench for vc_input_unit: stimulus pushes expected departures and
// credits into queues; a forked monitor pops and compares on every output.
module tb_vc_input_unit;

   localparam logic [1:0] T_BODY = 2'b00, T_TAIL = 2'b01, T_HEAD = 2'b10, T_HT = 2'b11;
   localparam logic [4:0] P_LOC = 5'b00001, P_S = 5'b00100, P_E = 5'b01000;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            in_valid = 1'b0;
   logic [1:0]      in_vc = '0;
   logic [31:0]     in_flit = '0;
   logic            upstr_credit;
   logic [1:0]      upstr_credit_vc;
   logic [3:0]      va_req;
   logic [3:0][4:0] va_dst_port;
   logic [3:0]      va_grant = '0;
   logic [3:0][1:0] va_grant_vc = '0;
   logic [3:0]      sa_req;
   logic [3:0]      sa_grant = '0;
   logic            out_valid;
   logic [31:0]     out_flit;
   logic [4:0]      out_port;
   logic [1:0]      out_vc;
   logic [1:0]      err_flags;

   typedef struct {
      logic [31:0] flit;
      logic [4:0]  port;
      logic [1:0]  vc;
   } exp_t;

   exp_t        exp_q[$];
   logic [1:0]  cred_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] pkt[$];

   always #5 clk = ~clk;

   vc_input_unit #(.FLIT_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
      .upstr_credit(upstr_credit), .upstr_credit_vc(upstr_credit_vc),
      .va_req(va_req), .va_dst_port(va_dst_port),
      .va_grant(va_grant), .va_grant_vc(va_grant_vc),
      .sa_req(sa_req), .sa_grant(sa_grant),
      .out_valid(out_valid), .out_flit(out_flit), .out_port(out_port), .out_vc(out_vc),
      .err_flags(err_flags)
   );

   function automatic logic [31:0] mk(logic [1:0] t, logic [3:0] d, logic [25:0] p);
      return {t, d, p};
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] vc, input logic [31:0] f);
      in_valid = 1'b1; in_vc = vc; in_flit = f;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic grant_va(input logic [1:0] vc, input logic [1:0] ovc);
      va_grant[vc] = 1'b1; va_grant_vc[vc] = ovc;
      tick();
      va_grant = '0; va_grant_vc = '0;
   endtask

   task automatic grant_sa(input logic [1:0] vc, input logic [31:0] f,
                           input logic [4:0] port, input logic [1:0] ovc);
      exp_t e;
      e.flit = f; e.port = port; e.vc = ovc;
      exp_q.push_back(e);
      cred_q.push_back(vc);
      sa_grant = 4'b0001 << vc;
      tick();
      sa_grant = '0;
   endtask

   task automatic monitor();
      exp_t e;
      logic [1:0] c;
      forever begin
         @(negedge clk);
         if (out_valid) begin
            if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("out_flit", out_flit, e.flit);
               chk("out_port", out_port, e.port);
               chk("out_vc", out_vc, e.vc);
            end
         end
         if (upstr_credit) begin
            if (cred_q.size() == 0) chk("unexpected_credit", 1, 0);
            else begin
               c = cred_q.pop_front();
               chk("credit_vc", upstr_credit_vc, c);
            end
         end
      end
   endtask

   initial begin
      fork
         monitor();
      join_none

      // reset state
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_credit", upstr_credit, 0);
      chk("rst_va_req", va_req, 0);
      chk("rst_sa_req", sa_req, 0);
      chk("rst_err", err_flags, 0);
      chk("rst_dst", va_dst_port, 0);
      tick(); tick();
      reset = 1'b1;
      tick();

      // 1: reset mid-packet, then a fresh HEADTAIL restarts cleanly
      push(0, mk(T_HEAD, 4'd0, 26'h11));
      push(0, mk(T_BODY, 4'd0, 26'h12));
      tick();
      chk("t1_va_req_pre", va_req, 4'b0001);
      grant_va(0, 1);
      chk("t1_sa_req_pre", sa_req, 4'b0001);
      reset = 1'b0;
      #1;
      chk("t1_async_sa_req", sa_req, 0);
      chk("t1_async_va_req", va_req, 0);
      tick();
      chk("t1_rst_out_valid", out_valid, 0);
      chk("t1_rst_credit", upstr_credit, 0);
      reset = 1'b1;
      tick();
      push(0, mk(T_HT, 4'd0, 26'h13));
      tick();
      chk("t1_routing_no_req", va_req, 0);
      tick();
      chk("t1_va_req", va_req, 4'b0001);
      chk("t1_dst_local", va_dst_port[0], P_LOC);
      grant_va(0, 2);
      grant_sa(0, mk(T_HT, 4'd0, 26'h13), P_LOC, 2);
      chk("t1_idle_after", sa_req, 0);

      // 2: HEADTAIL dest 5 into VC2 routes east
      push(2, mk(T_HT, 4'd5, 26'hAB));
      tick();
      chk("t2_va_req_t1", va_req, 0);
      tick();
      chk("t2_va_req_t2", va_req, 4'b0100);
      chk("t2_dst_east", va_dst_port[2], P_E);
      grant_va(2, 1);
      chk("t2_sa_req", sa_req, 4'b0100);
      grant_sa(2, mk(T_HT, 4'd5, 26'hAB), P_E, 1);
      chk("t2_vc2_idle_sa", sa_req, 0);
      chk("t2_vc2_idle_va", va_req, 0);

      // 3: 8-flit packet on VC1 toward south
      pkt.delete();
      pkt.push_back(mk(T_HEAD, 4'd12, 26'h300));
      for (int i = 1; i <= 6; i++) pkt.push_back(mk(T_BODY, 4'd0, 26'h300 + 26'(i)));
      pkt.push_back(mk(T_TAIL, 4'd0, 26'h3FF));
      foreach (pkt[i]) push(1, pkt[i]);
      chk("t3_va_req", va_req, 4'b0010);
      chk("t3_dst_south", va_dst_port[1], P_S);
      grant_va(1, 2);
      foreach (pkt[i]) grant_sa(1, pkt[i], P_S, 2);
      chk("t3_idle_sa", sa_req, 0);
      chk("t3_idle_va", va_req, 0);
      chk("t3_no_err", err_flags, 0);

      // 4: overflow VC3, then push+pop at full
      pkt.delete();
      pkt.push_back(mk(T_HEAD, 4'd3, 26'h400));
      for (int i = 1; i <= 7; i++) pkt.push_back(mk(T_BODY, 4'd0, 26'h400 + 26'(i)));
      foreach (pkt[i]) push(3, pkt[i]);
      chk("t4_no_err_at_full", err_flags, 0);
      push(3, mk(T_BODY, 4'd0, 26'hDEAD));
      chk("t4_full_err", err_flags, 2'b01);
      grant_va(3, 0);
      chk("t4_sa_req", sa_req, 4'b1000);
      in_valid = 1'b1; in_vc = 2'd3; in_flit = mk(T_TAIL, 4'd0, 26'h4FF);
      grant_sa(3, pkt[0], P_E, 0);
      in_valid = 1'b0;
      chk("t4_pushpop_no_err", err_flags, 2'b01);
      for (int i = 1; i <= 7; i++) grant_sa(3, pkt[i], P_E, 0);
      chk("t4_last_still_req", sa_req, 4'b1000);
      grant_sa(3, mk(T_TAIL, 4'd0, 26'h4FF), P_E, 0);
      chk("t4_drained", sa_req, 0);

      // 5: stray BODY discarded, then illegal multi-hot grant
      cred_q.push_back(2'd0);
      push(0, mk(T_BODY, 4'd0, 26'h500));
      tick();
      chk("t5_discard_err", err_flags, 2'b11);
      chk("t5_discard_no_req", va_req, 0);
      sa_grant = 4'b0011;
      tick();
      sa_grant = '0;
      chk("t5_multihot_err", err_flags, 2'b11);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("t5_err_cleared", err_flags, 0);
      va_grant[1] = 1'b1;
      tick();
      va_grant = '0;
      chk("t5_va_grant_idle_err", err_flags, 2'b10);
      chk("t5_va_grant_ignored", sa_req, 0);

      // 6: interleaved packets on VC0 (south) and VC1 (east)
      push(0, mk(T_HEAD, 4'd4, 26'h600));
      push(1, mk(T_HEAD, 4'd2, 26'h700));
      push(0, mk(T_BODY, 4'd0, 26'h601));
      push(1, mk(T_BODY, 4'd0, 26'h701));
      push(0, mk(T_TAIL, 4'd0, 26'h602));
      push(1, mk(T_TAIL, 4'd0, 26'h702));
      chk("t6_va_req", va_req, 4'b0011);
      chk("t6_dst0", va_dst_port[0], P_S);
      chk("t6_dst1", va_dst_port[1], P_E);
      va_grant = 4'b0011; va_grant_vc[0] = 2'd3; va_grant_vc[1] = 2'd2;
      tick();
      va_grant = '0; va_grant_vc = '0;
      chk("t6_sa_req", sa_req, 4'b0011);
      grant_sa(0, mk(T_HEAD, 4'd4, 26'h600), P_S, 3);
      grant_sa(1, mk(T_HEAD, 4'd2, 26'h700), P_E, 2);
      grant_sa(0, mk(T_BODY, 4'd0, 26'h601), P_S, 3);
      grant_sa(1, mk(T_BODY, 4'd0, 26'h701), P_E, 2);
      grant_sa(0, mk(T_TAIL, 4'd0, 26'h602), P_S, 3);
      grant_sa(1, mk(T_TAIL, 4'd0, 26'h702), P_E, 2);
      chk("t6_idle", sa_req, 0);

      repeat (3) tick();
      chk("out_queue_drained", exp_q.size(), 0);
      chk("credit_queue_drained", cred_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
